hazard_stall_controller: RTL

//  Pipeline sequencing controller for the 5-stage MIPS32 core; sits beside the ID stage.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/md_busy_tracker.sv | 31 +++
 rtl/hazard_stall_controller.sv | 114 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 decode constants and the hazard controller's sequencing modes.
package mips_pkg;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  // One sequencing mode is selected per cycle, highest priority first:
  // branch flush, stall, jump flush, normal run.
  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_STALL    = 2'd1,
    MODE_FLUSH_J  = 2'd2,
    MODE_FLUSH_BR = 2'd3
  } mode_t;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks how many cycles the multi-cycle MULT/DIV unit still owns HI/LO.
module md_busy_tracker #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic is_div,
  output logic md_active
);

  localparam logic [5:0] MULT_LD = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_LD  = 6'(DIV_CYCLES);

  logic [5:0] md_cnt;

  // Load the occupancy on issue, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt <= 6'd0;
    end else if (issue) begin
      md_cnt <= is_div ? DIV_LD : MULT_LD;
    end else if (md_cnt != 6'd0) begin
      md_cnt <= md_cnt - 6'd1;
    end
  end

  assign md_active = (md_cnt != 6'd0);

endmodule

// File: rtl/hazard_stall_controller.sv
// ID-stage sequencing controller: load-use, HI/LO and branch/jump hazard
// resolution with stall/flush performance counters.
module hazard_stall_controller
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int PERF_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [5:0]            id_opcode,
  input  logic [5:0]            id_funct,
  input  logic [4:0]            id_rs,
  input  logic [4:0]            id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_jump,
  input  logic                  ex_mem_read,
  input  logic [4:0]            ex_dest,
  input  logic                  ex_br_taken,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  md_busy,
  output logic [PERF_WIDTH-1:0] stall_cycles,
  output logic [PERF_WIDTH-1:0] flush_count
);

  function automatic logic [PERF_WIDTH-1:0] sat_inc(input logic [PERF_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic  load_use, is_md, is_div, is_hilo, md_haz, md_active, md_issue;
  mode_t mode;

  // Decode the ID instruction and compare its sources against the EX load.
  always_comb begin
    load_use = id_valid && ex_mem_read && (ex_dest != 5'd0) &&
               ((id_uses_rs && (id_rs == ex_dest)) || (id_uses_rt && (id_rt == ex_dest)));
    is_md    = id_valid && (id_opcode == OPC_SPECIAL) &&
               ((id_funct == FUNCT_MULT) || (id_funct == FUNCT_MULTU) ||
                (id_funct == FUNCT_DIV)  || (id_funct == FUNCT_DIVU));
    is_div   = (id_funct == FUNCT_DIV) || (id_funct == FUNCT_DIVU);
    is_hilo  = id_valid && (id_opcode == OPC_SPECIAL) &&
               ((id_funct == FUNCT_MFHI) || (id_funct == FUNCT_MFLO));
    md_haz   = (is_md || is_hilo) && md_active;
  end

  // Priority select of the cycle's mode and its pipeline control pattern;
  // reset forces everything to the safe squash-and-hold pattern.
  always_comb begin
    mode         = MODE_RUN;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (ex_br_taken) begin
      mode = MODE_FLUSH_BR;
    end else if (load_use || md_haz) begin
      mode = MODE_STALL;
    end else if (id_valid && id_jump) begin
      mode = MODE_FLUSH_J;
    end
    case (mode)
      MODE_FLUSH_BR: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      MODE_STALL: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
      end
      MODE_FLUSH_J: if_id_flush = 1'b1;
      default: ;
    endcase
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  // Only an instruction that actually leaves ID starts the MULT/DIV unit.
  assign md_issue = is_md && !rst && ((mode == MODE_RUN) || (mode == MODE_FLUSH_J));
  assign md_busy  = md_active && !rst;

  md_busy_tracker #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md (
    .clk      (clk),
    .rst      (rst),
    .issue    (md_issue),
    .is_div   (is_div),
    .md_active(md_active)
  );

  // Saturating stall/flush performance counters, frozen by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en)      stall_cycles <= sat_inc(stall_cycles);
      if (if_id_flush) flush_count  <= sat_inc(flush_count);
    end
  end

endmodule
